rotor_reverse: RTL

Return-path rotor for the Enigma datapath: it maps a letter entering a rotor's left contacts back out through its right contacts, which is the inverse of the forward rotor's right-to-left mapping. It holds its own stepping position and ring setting, and emits a turnover carry for the next rotor. The inverse permutation is not stored; a sequential scan of the forward wiring table finds each result. Letters enter and leave through valid/ready handshakes, so the block sits between the reflector output and the next-lower rotor on the return path.

---
 rtl/rotor_reverse.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/rotor_reverse.sv
// Return-path Enigma rotor: inverse mapping found by scanning the forward
// wiring table, with its own position/ring state and a turnover carry.
module rotor_reverse #(
    parameter int ROTOR_TYPE = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [4:0] in_letter,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [4:0] out_letter,
    output logic       out_err,
    input  logic       step,
    input  logic       load,
    input  logic [4:0] load_pos,
    input  logic [4:0] load_ring,
    output logic [4:0] pos,
    output logic       notch_hit
);

    localparam logic [207:0] WIRE =
        (ROTOR_TYPE == 2) ? "AJDKSIRUXBLHWTMCQGZNPYEVOF" :
        (ROTOR_TYPE == 3) ? "BDFHJLCPRTXVZNYEIWGAKMUSQO" :
                            "EKMFLGDQVZNTOWYHXUSPAIBRCJ";
    localparam logic [4:0] NOTCH =
        (ROTOR_TYPE == 2) ? 5'd4 : (ROTOR_TYPE == 3) ? 5'd21 : 5'd16;

    // Turn the ASCII wiring string into a letter-index table at elaboration.
    function automatic logic [25:0][4:0] build_tab(input logic [207:0] w);
        logic [25:0][4:0] tab;
        logic [7:0]       ch;
        tab = '0;
        for (int i = 0; i < 26; i++) begin
            ch     = w[8*(25-i) +: 8];
            tab[i] = 5'(ch - 8'd65);
        end
        return tab;
    endfunction

    localparam logic [25:0][4:0] FWD = build_tab(WIRE);

    // Reduce a biased sum (0..77) to 0..25; callers add 26 before subtracting.
    function automatic logic [4:0] mod26(input logic [6:0] v);
        if (v >= 7'd52)      return 5'(v - 7'd52);
        else if (v >= 7'd26) return 5'(v - 7'd26);
        else                 return v[4:0];
    endfunction

    typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

    state_t     state_q, state_d;
    logic [4:0] k_q, k_d;
    logic [4:0] t_q, t_d;
    logic [4:0] ps_q, ps_d;
    logic [4:0] rs_q, rs_d;
    logic [4:0] out_letter_q, out_letter_d;
    logic       out_err_q, out_err_d;
    logic [4:0] pos_q, pos_d;
    logic [4:0] ring_q, ring_d;
    logic       notch_q, notch_d;
    logic       load_ok;

    assign in_ready   = (state_q == IDLE) & ~rst;
    assign out_valid  = (state_q == DONE);
    assign out_letter = out_letter_q;
    assign out_err    = out_err_q;
    assign pos        = pos_q;
    assign notch_hit  = notch_q;

    // Letter FSM: accept/snapshot, scan the forward table, hold result.
    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        t_d          = t_q;
        ps_d         = ps_q;
        rs_d         = rs_q;
        out_letter_d = out_letter_q;
        out_err_d    = out_err_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (in_letter > 5'd25) begin
                        out_letter_d = in_letter;
                        out_err_d    = 1'b1;
                        state_d      = DONE;
                    end else begin
                        // Snapshot pre-step pos so a same-edge step can't leak in.
                        ps_d      = pos_q;
                        rs_d      = ring_q;
                        t_d       = mod26(7'(in_letter) + 7'(pos_q) + 7'd26 - 7'(ring_q));
                        k_d       = 5'd0;
                        out_err_d = 1'b0;
                        state_d   = SEARCH;
                    end
                end
            end
            SEARCH: begin
                if (FWD[k_q] == t_q) begin
                    out_letter_d = mod26(7'(k_q) + 7'(rs_q) + 7'd26 - 7'(ps_q));
                    state_d      = DONE;
                end else begin
                    k_d = k_q + 5'd1;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Position/ring update; load beats step, out-of-range loads are dropped.
    always_comb begin
        load_ok = load & (load_pos <= 5'd25) & (load_ring <= 5'd25);
        pos_d   = pos_q;
        ring_d  = ring_q;
        notch_d = 1'b0;
        if (load_ok) begin
            pos_d  = load_pos;
            ring_d = load_ring;
        end else if (step) begin
            pos_d   = (pos_q == 5'd25) ? 5'd0 : pos_q + 5'd1;
            notch_d = (pos_q == NOTCH);
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Datapath and rotor position registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_q          <= '0;
            t_q          <= '0;
            ps_q         <= '0;
            rs_q         <= '0;
            out_letter_q <= '0;
            out_err_q    <= 1'b0;
            pos_q        <= '0;
            ring_q       <= '0;
            notch_q      <= 1'b0;
        end else begin
            k_q          <= k_d;
            t_q          <= t_d;
            ps_q         <= ps_d;
            rs_q         <= rs_d;
            out_letter_q <= out_letter_d;
            out_err_q    <= out_err_d;
            pos_q        <= pos_d;
            ring_q       <= ring_d;
            notch_q      <= notch_d;
        end
    end

endmodule
